axifull_rd_to_axis: RTL

//  Read-side counterpart of the stream-to-DDR writer: fetches a buffered packet from memory over AXI4-Full
//  and replays it as a 64-bit AXI-Stream. A request names the start address, burst count and tdest.
//  One burst is outstanding at a time; R beats pass through a 2-entry skid buffer to m_axis.

---
 rtl/ssrnet_axi_pkg.sv | 22 ++
 rtl/axis_skid_buf.sv | 90 +++++++++
 rtl/axifull_rd_to_axis.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ssrnet_axi_pkg.sv
// ----------------------------------------------------------------------------
// ssrnet_axi_pkg
// Shared AXI4 encodings and the read-engine FSM state type used by
// axifull_rd_to_axis and its helpers.
//  - AXI_BURST_INCR / AXI_SIZE_8B / AXI_RESP_OKAY / AXI_CACHE_DEF : AXI field values
//  - rd_state_e : read-engine FSM states (Idle -> Ar -> Rd -> (Ar | Drain) -> Idle)
// ----------------------------------------------------------------------------
package ssrnet_axi_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAr    = 2'd1,
      StRd    = 2'd2,
      StDrain = 2'd3
   } rd_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// ----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry skid buffer carrying data + last + dest. The output side is fully
// registered; in_ready_o depends only on the stored occupancy, so there is no
// combinational path from out_ready_i back to the input side.
// Ports:
//  clk_i, rst_i         clock, asynchronous active-high reset
//  in_valid_i/ready_o   upstream handshake, in_data_i/in_last_i/in_dest_i payload
//  out_valid_o/ready_i  downstream handshake, out_data_o/out_last_o/out_dest_o payload
//  empty_o              no entry stored
// ----------------------------------------------------------------------------
module axis_skid_buf #(
   parameter int unsigned DataW = 64,
   parameter int unsigned DestW = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [DataW-1:0] in_data_i,
   input  logic             in_last_i,
   input  logic [DestW-1:0] in_dest_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DataW-1:0] out_data_o,
   output logic             out_last_o,
   output logic [DestW-1:0] out_dest_o,
   output logic             empty_o
);

   logic [1:0]       cnt_q, cnt_d;
   logic [DataW-1:0] head_data_q, spare_data_q;
   logic             head_last_q, spare_last_q;
   logic [DestW-1:0] head_dest_q, spare_dest_q;
   logic             push, pop;
   logic             head_from_in, head_from_spare, spare_load;

   assign in_ready_o  = (cnt_q != 2'd2);
   assign out_valid_o = (cnt_q != 2'd0);
   assign empty_o     = (cnt_q == 2'd0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   // Head takes the new beat when it is (or is about to become) the oldest entry.
   assign head_from_in    = push & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & pop));
   assign head_from_spare = pop & (cnt_q == 2'd2);
   assign spare_load      = push & ~pop & (cnt_q == 2'd1);

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q        <= 2'd0;
         head_data_q  <= '0;
         head_last_q  <= 1'b0;
         head_dest_q  <= '0;
         spare_data_q <= '0;
         spare_last_q <= 1'b0;
         spare_dest_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (head_from_in) begin
            head_data_q <= in_data_i;
            head_last_q <= in_last_i;
            head_dest_q <= in_dest_i;
         end else if (head_from_spare) begin
            head_data_q <= spare_data_q;
            head_last_q <= spare_last_q;
            head_dest_q <= spare_dest_q;
         end
         if (spare_load) begin
            spare_data_q <= in_data_i;
            spare_last_q <= in_last_i;
            spare_dest_q <= in_dest_i;
         end
      end
   end

   assign out_data_o = head_data_q;
   assign out_last_o = head_last_q;
   assign out_dest_o = head_dest_q;

endmodule

// File: rtl/axifull_rd_to_axis.sv
// ----------------------------------------------------------------------------
// axifull_rd_to_axis
// Fetches a packet from memory as a sequence of fixed-length AXI4 INCR bursts
// (one outstanding at a time) and replays it on a 64-bit AXI-Stream.
// Ports:
//  M_AXI_ACLK / M_AXI_ARESET        clock, asynchronous active-high reset
//  req_valid/req_ready, req_addr, req_nburst, req_dest   packet request
//  done                             one-cycle pulse after the last stream beat
//  rd_err                           sticky read error flag
//  M_AXI_AR* / M_AXI_R*             AXI4 read address and data channels
//  m_axis_*                         AXI-Stream master output
// Build option: define RD_RLAST_CHECK_EN to flag RLAST that disagrees with the
// beat counter; otherwise RLAST is ignored.
// ----------------------------------------------------------------------------
module axifull_rd_to_axis
   import ssrnet_axi_pkg::*;
#(
   parameter int unsigned C_M_AXI_BURST_LEN  = 16,
   parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 64
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]                    req_nburst,
   input  logic [2:0]                    req_dest,
   output logic                          done,
   output logic                          rd_err,
   output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARLOCK,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic [3:0]                    M_AXI_ARQOS,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [7:0]                    m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic [2:0]                    m_axis_tdest
);

   localparam int unsigned AW      = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned BeatW   = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
   localparam int unsigned AddrLsb = $clog2(C_M_AXI_BURST_LEN * 8);
   // Start address is forced to a burst boundary, which also keeps bursts inside 4KB.
   localparam logic [AW-1:0]    AddrMask   = {{(AW - AddrLsb){1'b1}}, {AddrLsb{1'b0}}};
   localparam logic [AW-1:0]    BurstBytes = AW'(C_M_AXI_BURST_LEN * 8);
   localparam logic [7:0]       ArLen      = 8'(C_M_AXI_BURST_LEN - 1);
   localparam logic [BeatW-1:0] LastBeat   = BeatW'(C_M_AXI_BURST_LEN - 1);

   rd_state_e        state_q;
   logic [AW-1:0]    cur_addr_q;
   logic [7:0]       burst_cnt_q;
   logic [BeatW-1:0] beat_cnt_q;
   logic [2:0]       dest_q;
   logic             arvalid_q, done_q, req_ready_q, rd_err_q;

   logic r_hs, last_beat, rlast_bad;
   logic skid_in_valid, skid_in_ready, skid_last, skid_empty;
   logic unused_in;

   assign unused_in = ^{M_AXI_RID, M_AXI_RLAST};

   assign last_beat     = (beat_cnt_q == LastBeat);
   assign skid_in_valid = M_AXI_RVALID & (state_q == StRd);
   assign M_AXI_RREADY  = (state_q == StRd) & skid_in_ready;
   assign r_hs          = M_AXI_RVALID & M_AXI_RREADY;
   assign skid_last     = (burst_cnt_q == 8'd1) & last_beat;

`ifdef RD_RLAST_CHECK_EN
   // Beat counter remains authoritative; RLAST only contributes to the error flag.
   assign rlast_bad = r_hs & (M_AXI_RLAST != last_beat);
`else
   assign rlast_bad = 1'b0;
`endif

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q     <= StIdle;
         cur_addr_q  <= '0;
         burst_cnt_q <= 8'd0;
         beat_cnt_q  <= '0;
         dest_q      <= 3'd0;
         arvalid_q   <= 1'b0;
         done_q      <= 1'b0;
         req_ready_q <= 1'b0;
         rd_err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (r_hs && ((M_AXI_RRESP != AXI_RESP_OKAY) || rlast_bad)) begin
            rd_err_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               req_ready_q <= 1'b1;
               if (req_ready_q && req_valid) begin
                  cur_addr_q  <= req_addr & AddrMask;
                  burst_cnt_q <= req_nburst;
                  dest_q      <= req_dest;
                  if (req_nburst == 8'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     req_ready_q <= 1'b0;
                     arvalid_q   <= 1'b1;
                     state_q     <= StAr;
                  end
               end
            end
            StAr: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q  <= 1'b0;
                  beat_cnt_q <= '0;
                  state_q    <= StRd;
               end
            end
            StRd: begin
               if (r_hs) begin
                  beat_cnt_q <= beat_cnt_q + BeatW'(1);
                  if (last_beat) begin
                     beat_cnt_q  <= '0;
                     cur_addr_q  <= cur_addr_q + BurstBytes;
                     burst_cnt_q <= burst_cnt_q - 8'd1;
                     if (burst_cnt_q > 8'd1) begin
                        arvalid_q <= 1'b1;
                        state_q   <= StAr;
                     end else begin
                        state_q <= StDrain;
                     end
                  end
               end
            end
            StDrain: begin
               // Final R beat is already in the skid; wait for it to leave the stream.
               if (skid_empty) begin
                  done_q      <= 1'b1;
                  req_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   axis_skid_buf #(
      .DataW (C_M_AXI_DATA_WIDTH),
      .DestW (3)
   ) u_skid (
      .clk_i       (M_AXI_ACLK),
      .rst_i       (M_AXI_ARESET),
      .in_valid_i  (skid_in_valid),
      .in_ready_o  (skid_in_ready),
      .in_data_i   (M_AXI_RDATA),
      .in_last_i   (skid_last),
      .in_dest_i   (dest_q),
      .out_valid_o (m_axis_tvalid),
      .out_ready_i (m_axis_tready),
      .out_data_o  (m_axis_tdata),
      .out_last_o  (m_axis_tlast),
      .out_dest_o  (m_axis_tdest),
      .empty_o     (skid_empty)
   );

   assign req_ready     = req_ready_q;
   assign done          = done_q;
   assign rd_err        = rd_err_q;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = cur_addr_q;
   assign M_AXI_ARLEN   = ArLen;
   assign M_AXI_ARSIZE  = AXI_SIZE_8B;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = AXI_CACHE_DEF;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'b0000;
   assign M_AXI_ARVALID = arvalid_q;
   assign m_axis_tkeep  = 8'hFF;

endmodule
